// File: rtl/seq_detect_multi.sv
// rtl/seq_detect_multi.sv - multi-channel serial pattern detector with per-channel hit counters
module seq_detect_multi #(
  parameter int                CH      = 4,
  parameter int                LEN     = 4,
  parameter logic [LEN-1:0]    PATTERN = 4'b1101,
  parameter int                CNT_W   = 8
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic [CH-1:0]         in,
  input  logic [CH-1:0]         in_valid,
  input  logic                  overlap,
  input  logic                  clr,
  output logic [CH-1:0]         out,
  output logic [CH*CNT_W-1:0]   hit_cnt
);

  localparam int SW = $clog2(LEN);

  // Prefix character i (0 = first bit received) of the pattern.
  function automatic logic pat_bit(input int i);
    return PATTERN[LEN-1-i];
  endfunction

  // Next-state table for one input bit value: longest pattern prefix that is a
  // suffix of (matched prefix of length s) followed by b.
  function automatic logic [LEN-1:0][SW-1:0] build_table(input logic b);
    logic [LEN-1:0][SW-1:0] t;
    int   best;
    int   j;
    logic ok;
    logic ch;
    t = '0;
    for (int s = 0; s < LEN; s++) begin
      best = 0;
      for (int k = 1; k <= s + 1; k++) begin
        if (k < LEN) begin
          ok = 1'b1;
          for (int i = 0; i < k; i++) begin
            j  = s + 1 - k + i;
            ch = (j == s) ? b : pat_bit(j);
            if (ch != pat_bit(i)) ok = 1'b0;
          end
          if (ok) best = k;
        end
      end
      t[s] = SW'(best);
    end
    return t;
  endfunction

  // Longest proper border of the whole pattern: the restart point after an
  // overlapping detection.
  function automatic logic [SW-1:0] calc_border();
    int   best;
    logic ok;
    best = 0;
    for (int k = 1; k < LEN; k++) begin
      ok = 1'b1;
      for (int i = 0; i < k; i++) begin
        if (pat_bit(i) != pat_bit(LEN - k + i)) ok = 1'b0;
      end
      if (ok) best = k;
    end
    return SW'(best);
  endfunction

  localparam logic [LEN-1:0][SW-1:0] NXT0   = build_table(1'b0);
  localparam logic [LEN-1:0][SW-1:0] NXT1   = build_table(1'b1);
  localparam logic [SW-1:0]          BORDER = calc_border();
  localparam logic [SW-1:0]          LAST   = SW'(LEN - 1);
  localparam logic [CNT_W-1:0]       CMAX   = {CNT_W{1'b1}};

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [SW-1:0]    r_state;
    logic             r_out;
    logic [CNT_W-1:0] r_cnt;
    logic             w_det;
    logic [SW-1:0]    w_nxt;

    assign w_det = in_valid[c] && (r_state == LAST) && (in[c] == PATTERN[0]);
    assign w_nxt = in[c] ? NXT1[r_state] : NXT0[r_state];

    // clr outranks any detection on the same edge, so that hit is dropped.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
        r_state <= '0;
        r_out   <= 1'b0;
        r_cnt   <= '0;
      end else if (clr) begin
        r_state <= '0;
        r_out   <= 1'b0;
        r_cnt   <= '0;
      end else begin
        r_out <= w_det;
        if (w_det) begin
          r_state <= overlap ? BORDER : '0;
          if (r_cnt != CMAX) r_cnt <= r_cnt + CNT_W'(1);
        end else if (in_valid[c]) begin
          r_state <= w_nxt;
        end
      end
    end

    assign out[c]                    = r_out;
    assign hit_cnt[c*CNT_W +: CNT_W] = r_cnt;
  end

endmodule

// File: tb/tb_seq_detect_multi.sv
// tb/tb_seq_detect_multi.sv - scoreboard bench for seq_detect_multi against a sliding-window model
module tb_seq_detect_multi;

  localparam int             CH      = 4;
  localparam int             LEN     = 4;
  localparam int             CNT_W   = 8;
  localparam logic [LEN-1:0] PATTERN = 4'b1101;
  localparam int             CMAX    = 255;
  localparam int             CMAX2   = 3;

  logic                sys_clk = 1'b0;
  logic                sys_rst = 1'b1;
  logic [CH-1:0]       in_b    = '0;
  logic [CH-1:0]       in_v    = '0;
  logic                ov      = 1'b1;
  logic                clr     = 1'b0;
  logic [CH-1:0]       out;
  logic [CH*CNT_W-1:0] hit_cnt;
  logic [0:0]          out2;
  logic [1:0]          hit_cnt2;

  int tests = 0;
  int fails = 0;

  always #5 sys_clk = ~sys_clk;

  seq_detect_multi #(.CH(CH), .LEN(LEN), .PATTERN(PATTERN), .CNT_W(CNT_W)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .in(in_b), .in_valid(in_v),
    .overlap(ov), .clr(clr), .out(out), .hit_cnt(hit_cnt)
  );

  seq_detect_multi #(.CH(1), .LEN(LEN), .PATTERN(PATTERN), .CNT_W(2)) dut2 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .in(in_b[0]), .in_valid(in_v[0]),
    .overlap(ov), .clr(clr), .out(out2), .hit_cnt(hit_cnt2)
  );

  typedef struct packed {
    logic [CH-1:0]       o;
    logic [CH*CNT_W-1:0] cnt;
    logic                o2;
    logic [1:0]          c2;
  } exp_t;

  exp_t exp_q[$];

  // Model: bits consumed since the last restart point; a hit is the last LEN of them equalling PATTERN.
  logic [LEN-1:0] m_win [CH];
  int             m_n   [CH];
  int             m_cnt [CH];
  int             m_cnt2;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < CH; c++) begin
      m_win[c] = '0;
      m_n[c]   = 0;
      m_cnt[c] = 0;
    end
    m_cnt2 = 0;
  endtask

  task automatic step();
    exp_t e;
    e = '0;
    if (sys_rst || clr) begin
      model_clear();
    end else begin
      for (int c = 0; c < CH; c++) begin
        if (in_v[c]) begin
          m_win[c] = {m_win[c][LEN-2:0], in_b[c]};
          if (m_n[c] < LEN) m_n[c]++;
          if (m_n[c] == LEN && m_win[c] == PATTERN) begin
            e.o[c] = 1'b1;
            if (m_cnt[c] < CMAX) m_cnt[c]++;
            if (c == 0) begin
              e.o2 = 1'b1;
              if (m_cnt2 < CMAX2) m_cnt2++;
            end
            if (!ov) begin
              m_win[c] = '0;
              m_n[c]   = 0;
            end
          end
        end
      end
    end
    for (int c = 0; c < CH; c++) e.cnt[c*CNT_W +: CNT_W] = CNT_W'(m_cnt[c]);
    e.c2 = 2'(m_cnt2);
    exp_q.push_back(e);
    @(posedge sys_clk);
    #2;
  endtask

  task automatic send(input logic [CH-1:0] v, input logic [CH-1:0] b);
    in_v = v;
    in_b = b;
    step();
  endtask

  task automatic send_ch0(input logic [31:0] bits, input int n, input int gap);
    for (int i = n - 1; i >= 0; i--) begin
      send(4'b0001, {3'b000, bits[i]});
      for (int g = 0; g < gap; g++) send(4'b0000, 4'b1111);
    end
  endtask

  task automatic do_clr();
    clr = 1'b1;
    send('0, '0);
    clr = 1'b0;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge sys_clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("out", 64'(out), 64'(e.o));
        check("hit_cnt", 64'(hit_cnt), 64'(e.cnt));
        check("out_cw2", 64'(out2), 64'(e.o2));
        check("hit_cnt_cw2", 64'(hit_cnt2), 64'(e.c2));
      end
    end
  end

  initial begin
    model_clear();
    #1;
    check("reset_out", 64'(out), 64'(0));
    check("reset_cnt", 64'(hit_cnt), 64'(0));
    #1;
    send('0, '0);
    send('1, '1);
    sys_rst = 1'b0;

    ov = 1'b1;
    send_ch0(32'b1101101, 7, 0);
    do_clr();
    ov = 1'b0;
    send_ch0(32'b1101101, 7, 0);
    send_ch0(32'b11, 2, 0);
    do_clr();
    send_ch0(32'b1101, 4, 2);
    do_clr();
    send(4'b0110, 4'b0010);
    send(4'b0110, 4'b0010);
    send(4'b0110, 4'b0000);
    send(4'b0110, 4'b0010);
    send(4'b0000, 4'b0000);
    do_clr();
    ov = 1'b0;
    for (int r = 0; r < 5; r++) send_ch0(32'b1101, 4, 0);
    ov = 1'b1;
    send_ch0(32'b1111, 4, 0);

    send_ch0(32'b110, 3, 0);
    sys_rst = 1'b1;
    #1;
    check("async_rst_out", 64'(out), 64'(0));
    check("async_rst_cnt", 64'(hit_cnt), 64'(0));
    model_clear();
    send('0, '0);
    sys_rst = 1'b0;
    send_ch0(32'b1, 1, 0);
    send('0, '0);

    do_clr();
    send_ch0(32'b110, 3, 0);
    clr = 1'b1;
    send(4'b0001, 4'b0001);
    clr = 1'b0;
    send('0, '0);

    for (int i = 0; i < 600; i++) begin
      ov  = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 79) == 0);
      send(CH'($urandom | $urandom), CH'($urandom));
    end
    clr = 1'b0;
    send('0, '0);

    repeat (3) @(posedge sys_clk);
    #2;
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
